// File: rtl/s713_ctrl_pkg.sv
// s713_ctrl_pkg: shared types and default widths for the s713 step controller.
//   cmd_op_e      - command opcodes carried on cmd_op
//   ctrl_state_e  - sequencing FSM states
//   *_W_DEF       - default core widths (state bank, primary inputs/outputs)
package s713_ctrl_pkg;

  localparam int unsigned STATE_W_DEF = 19;
  localparam int unsigned PI_W_DEF    = 35;
  localparam int unsigned PO_W_DEF    = 23;

  typedef enum logic [1:0] {
    OP_NOP   = 2'd0,
    OP_LOAD  = 2'd1,
    OP_CLEAR = 2'd2,
    OP_RUN   = 2'd3
  } cmd_op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EVAL  = 3'd2,
    ST_EMIT  = 3'd3,
    ST_DONE  = 3'd4
  } ctrl_state_e;

endpackage

// File: rtl/s713_step_ctrl.sv
// s713_step_ctrl: sequencing controller for the combinational s713 core.
// Holds the core's state-register bank and steps the core one functional
// clock per accepted primary-input vector, capturing next-state and outputs
// after SETTLE extra evaluation cycles.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   cmd_valid/ready/op/count/state - command channel (NOP/LOAD/CLEAR/RUN)
//   halt                     - stop a RUN at the next FETCH or EMIT handshake
//   pi_valid/ready/data      - primary-input vector stream
//   core_pi, core_state      - registered drive into the core
//   core_next, core_po       - combinational core results
//   po_valid/ready/data/state - one output beat per step
//   busy, done, step_cnt     - status
module s713_step_ctrl
  import s713_ctrl_pkg::*;
#(
  parameter int unsigned STATE_W = STATE_W_DEF,
  parameter int unsigned PI_W    = PI_W_DEF,
  parameter int unsigned PO_W    = PO_W_DEF,
  parameter int unsigned SETTLE  = 0,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [CNT_W-1:0]   cmd_count,
  input  logic [STATE_W-1:0] cmd_state,
  input  logic               halt,
  input  logic               pi_valid,
  output logic               pi_ready,
  input  logic [PI_W-1:0]    pi_data,
  output logic [PI_W-1:0]    core_pi,
  output logic [STATE_W-1:0] core_state,
  input  logic [STATE_W-1:0] core_next,
  input  logic [PO_W-1:0]    core_po,
  output logic               po_valid,
  input  logic               po_ready,
  output logic [PO_W-1:0]    po_data,
  output logic [STATE_W-1:0] po_state,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   step_cnt
);

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE);

  ctrl_state_e        fsm_q, fsm_d;
  logic [STATE_W-1:0] state_q, state_d;
  logic [PI_W-1:0]    pi_q, pi_d;
  logic [PO_W-1:0]    po_q, po_d;
  logic [STATE_W-1:0] nxt_q, nxt_d;
  logic [CNT_W-1:0]   step_cnt_q, step_cnt_d;
  logic [CNT_W-1:0]   remaining_q, remaining_d;
  logic [3:0]         settle_q, settle_d;
  cmd_op_e            op;

  assign op = cmd_op_e'(cmd_op);

  always_comb begin
    fsm_d       = fsm_q;
    state_d     = state_q;
    pi_d        = pi_q;
    po_d        = po_q;
    nxt_d       = nxt_q;
    step_cnt_d  = step_cnt_q;
    remaining_d = remaining_q;
    settle_d    = settle_q;
    cmd_ready   = 1'b0;
    pi_ready    = 1'b0;
    po_valid    = 1'b0;
    done        = 1'b0;

    case (fsm_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          case (op)
            OP_NOP:   ;
            OP_LOAD:  state_d = cmd_state;
            OP_CLEAR: state_d = '0;
            OP_RUN: begin
              remaining_d = cmd_count;
              step_cnt_d  = '0;
              fsm_d       = (cmd_count == '0) ? ST_DONE : ST_FETCH;
            end
          endcase
        end
      end

      ST_FETCH: begin
        // halt wins over a simultaneous vector; ready is withheld so the
        // source never sees a handshake for a vector that is not consumed.
        pi_ready = ~halt;
        if (halt) begin
          fsm_d = ST_DONE;
        end else if (pi_valid) begin
          pi_d     = pi_data;
          settle_d = SETTLE_INIT;
          fsm_d    = ST_EVAL;
        end
      end

      ST_EVAL: begin
        if (settle_q == '0) begin
          po_d  = core_po;
          nxt_d = core_next;
          fsm_d = ST_EMIT;
        end else begin
          settle_d = settle_q - 4'd1;
        end
      end

      ST_EMIT: begin
        po_valid = 1'b1;
        if (po_ready) begin
          state_d     = nxt_q;
          step_cnt_d  = step_cnt_q + CNT_W'(1);
          remaining_d = remaining_q - CNT_W'(1);
          fsm_d       = (remaining_q == CNT_W'(1) || halt) ? ST_DONE : ST_FETCH;
        end
      end

      ST_DONE: begin
        done  = 1'b1;
        fsm_d = ST_IDLE;
      end

      default: fsm_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q       <= ST_IDLE;
      state_q     <= '0;
      pi_q        <= '0;
      po_q        <= '0;
      nxt_q       <= '0;
      step_cnt_q  <= '0;
      remaining_q <= '0;
      settle_q    <= '0;
    end else begin
      fsm_q       <= fsm_d;
      state_q     <= state_d;
      pi_q        <= pi_d;
      po_q        <= po_d;
      nxt_q       <= nxt_d;
      step_cnt_q  <= step_cnt_d;
      remaining_q <= remaining_d;
      settle_q    <= settle_d;
    end
  end

  assign core_pi    = pi_q;
  assign core_state = state_q;
  assign po_data    = po_q;
  assign po_state   = nxt_q;
  assign step_cnt   = step_cnt_q;
  assign busy       = (fsm_q != ST_IDLE);

endmodule
